// File: rtl/fc_mac_controller_pkg.sv
// Shared FC definitions: controller state encoding, default operand width and
// a ceil(log2) helper for deriving accumulator widths.
package fc_mac_controller_pkg;

  localparam int unsigned N_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_controller_mult.sv
// Combinational radix-2 Booth multiplier shared by the FC MAC controller.
// m is the multiplicand (M port), r the multiplier (R port).
module fc_mac_controller_mult
  import fc_mac_controller_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic signed [N-1:0]   m,
  input  logic signed [N-1:0]   r,
  output logic signed [2*N-1:0] p
);

  logic signed [2*N-1:0] m_ext;
  logic        [N:0]     r_ext;

  // Each adjacent multiplier bit pair {r[i], r[i-1]} selects +M, -M or nothing.
  always_comb begin
    m_ext = {{N{m[N-1]}}, m};
    r_ext = {r, 1'b0};
    p     = '0;
    for (int i = 0; i < int'(N); i++) begin
      case (r_ext[i+1 -: 2])
        2'b01:   p = p + (m_ext <<< i);
        2'b10:   p = p - (m_ext <<< i);
        default: p = p;
      endcase
    end
  end

endmodule

// File: rtl/fc_mac_controller.sv
// Single FC neuron sequencer: streams LEN act/wgt pairs from synchronous-read
// buffers through a shared Booth multiplier and accumulates onto a bias.
module fc_mac_controller
  import fc_mac_controller_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned LEN   = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned ACC_W = 2*N + 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] bias,
  output logic        [AW-1:0]    addr,
  input  logic signed [N-1:0]     act_in,
  input  logic signed [N-1:0]     wgt_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] result
);

  localparam logic [AW-1:0]       LAST_ADDR = AW'(LEN - 1);
  localparam logic signed [N-1:0] ACT_MIN   = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [N-1:0] ACT_CLAMP = {1'b1, {(N-2){1'b0}}, 1'b1};

  state_e state_q, state_d;

  logic                    rd_vld_q, rd_last_q;
  logic                    prod_vld_q, prod_last_q;
  logic signed [2*N-1:0]   prod_q, prod_c;
  logic signed [N-1:0]     act_op_c;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum_c, result_d;
  logic        [AW-1:0]    addr_d;
  logic                    busy_d, done_d;

  // The multiplier cannot take the most negative M; nudge it by one LSB.
  assign act_op_c = (act_in == ACT_MIN) ? ACT_CLAMP : act_in;
  assign sum_c    = acc_q + {{(ACC_W-2*N){prod_q[2*N-1]}}, prod_q};

  fc_mac_controller_mult #(.N(N)) u_mult (
    .m (act_op_c),
    .r (wgt_in),
    .p (prod_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (addr == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN: if (prod_vld_q && prod_last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    acc_d    = prod_vld_q ? sum_c : acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d  = bias;
          addr_d = '0;
          busy_d = 1'b1;
        end
      end
      S_FETCH: addr_d = (addr == LAST_ADDR) ? '0 : addr + AW'(1);
      S_DRAIN: begin
        if (prod_vld_q && prod_last_q) begin
          result_d = sum_c;
          done_d   = 1'b1;
        end
      end
      S_DONE:  busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // Pipeline: address -> read data (rd_*) -> product (prod_*) -> accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
    end else begin
      addr        <= addr_d;
      busy        <= busy_d;
      done        <= done_d;
      result      <= result_d;
      acc_q       <= acc_d;
      rd_vld_q    <= (state_q == S_FETCH);
      rd_last_q   <= (state_q == S_FETCH) && (addr == LAST_ADDR);
      prod_vld_q  <= rd_vld_q;
      prod_last_q <= rd_last_q;
      if (rd_vld_q) prod_q <= prod_c;
    end
  end

endmodule

// File: doc/fc_mac_controller.md
Name: fc_mac_controller

Overview:
- Sequences one fully-connected neuron: streams LEN activation/weight pairs from synchronous-read memories.
- Drives a single shared combinational Booth multiplier (Multiplier) and accumulates the signed products onto a bias.
- Reports the dot product with a start/done handshake.
- Sits between the FC layer's top-level control and its activation and weight buffers.

Parameters:
- N, 5, operand width (signed two's complement) for activations and weights.
- LEN, 16, number of MAC terms per neuron; must be ≥1.
- AW, 4, address width; must satisfy 2^AW ≥ LEN.
- ACC_W, 2*N+4, accumulator/result width; must be ≥ 2*N + ceil(log2(LEN)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a neuron; sampled only in IDLE.
- bias  in  ACC_W  signed bias; sampled at the accepted start edge.
- addr  out  AW  read address, shared by both memories.
- act_in  in  N  activation read data; valid the cycle after addr is presented.
- wgt_in  in  N  weight read data; same timing as act_in.
- busy  out  1  high from the start edge until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  ACC_W  signed dot product plus bias; held until next done.

Behaviour:
- Reset (async, immediate): state=IDLE; addr=0, busy=0, done=0, result=0; accumulator, product register and counters cleared. Reset mid-operation aborts the neuron; no done is issued.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 at edge E0: acc←bias, addr←0, busy←1, state→FETCH.
  - start=0: stay in IDLE.
- FETCH:
  - addr increments by 1 each edge through LEN-1.
  - At the edge where addr=LEN-1: addr←0, state→DRAIN.
  - LEN=1: FETCH lasts exactly one cycle.
- Datapath pipeline:
  - Memory returns pair k in the cycle after addr=k.
  - The multiplier is combinational; M=act operand, R=wgt operand.
  - Product is registered into prod_q (2N bits) at the next edge, with a valid bit.
  - Next edge: acc←acc + sign-extended prod_q.
- DRAIN: waits for the last product to accumulate. At the edge that accumulates term LEN-1: result←acc+prod_q, done←1, state→DONE.
- DONE: one cycle. At its closing edge: done←0, busy←0, state→IDLE.
  - A start in DONE is ignored; start is accepted only from IDLE.
- Latency: done is high in the cycle after edge E0+LEN+2. Start-to-start minimum is LEN+4 cycles.
- start while busy: ignored. No queuing. bias is not re-sampled.
- Operand guard: the Booth multiplier mis-handles M=-2^(N-1).
  - Controller clamps act to -2^(N-1)+1 before the M port (e.g. N=5: -16→-15).
  - The weight feeds R unmodified; the full range is legal.
- Arithmetic: all signed; the accumulator wraps modulo 2^ACC_W. Overflow is excluded by the ACC_W sizing rule, so there is no saturation.

Decomposition:
- Shared FC package holds:
  - state encoding constants (IDLE=0, FETCH=1, DRAIN=2, DONE=3);
  - the ACC_W derivation helper (clog2 function);
  - the N default.
- One sub-module: the existing Multiplier, instantiated once with N passed through.
- Clamp, counter and accumulator stay inline.

Test Plan:
- Reset: rst=1 mid-run with LEN=4 → all outputs 0 immediately, IDLE, no done; next start gives a correct result.
- Basic (N=5, LEN=4, bias=0):
  - act={1,2,3,4}, wgt={5,6,7,8} → result=70.
  - done pulses exactly once, in the cycle after E0+6.
  - busy is high for 7 cycles.
- Signs/bias: act={-3,7,-1,2}, wgt={4,-5,-6,-8}, bias=10 → -12-35+6-16+10 = -47.
- Clamp corner:
  - act={-16,-16,0,0}, wgt={-16,15,0,0} → (-15)(-16)+(-15)(15) = 15.
  - act={1,…}, wgt={-16,…} → R path exact.
- Handshake:
  - start held high through the whole run → exactly one done, then immediate re-accept from IDLE.
  - Pulse start during FETCH → ignored; result unchanged.
- LEN=1 build: act=-7, wgt=9, bias=-1 → result=-64; done in the cycle after E0+3.
